fb_arbiter: RTL and testbench

Single-port framebuffer memory arbiter between the SVGA pixel prefetcher and the SPI host interface. Video gets fixed priority. A starvation counter guarantees the SPI side one access slot after a bounded wait. A per-frame stall counter reports how often video was held off. The block sits between the SPI command decoder, the line prefetcher and the framebuffer SRAM macro inside `top`.

---
 rtl/fb_arbiter.sv | 129 ++++++++++++
 tb/tb_fb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer SRAM arbiter: video has fixed priority over SPI; a starvation
// counter forces one SPI slot after STARVE_LIMIT waits; video stalls are counted per frame.
module fb_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_gnt_o,
  output logic              vid_rvalid_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  input  logic              spi_req_i,
  input  logic              spi_we_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [DATA_W-1:0] spi_wdata_i,
  output logic              spi_gnt_o,
  output logic              spi_rvalid_o,
  output logic [DATA_W-1:0] spi_rdata_o,
  input  logic              next_frame_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [7:0]        stall_last_o,
  output logic [1:0]        dbg_state_o,
  output logic [3:0]        dbg_wait_o
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] VID       = 2'd1;
  localparam logic [1:0] SPI_FORCE = 2'd2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  logic [1:0]        state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [7:0]        stall_cnt, stall_sum;
  logic              stall_inc;
  logic              force_nxt;
  logic              vid_pend, spi_pend;
  logic [DATA_W-1:0] vid_rdata_q, spi_rdata_q;

  // Handshake: a requester holds req (and its fields) until the cycle its gnt
  // is high; that cycle is the transfer, and req may drop or re-arm afterwards.
  always_comb begin
    vid_gnt_o = 1'b0;
    spi_gnt_o = 1'b0;
    case (state)
      SPI_FORCE: spi_gnt_o = spi_req_i;
      default: begin
        if (vid_req_i) vid_gnt_o = 1'b1;
        else           spi_gnt_o = spi_req_i;
      end
    endcase
  end

  assign force_nxt = spi_req_i && !spi_gnt_o && (wait_cnt == LIMIT);

  always_comb begin
    state_nxt = IDLE;
    if (force_nxt) begin
      state_nxt = SPI_FORCE;
    end else begin
      case (state)
        IDLE:      state_nxt = vid_req_i ? VID : IDLE;
        VID:       state_nxt = vid_req_i ? VID : IDLE;
        SPI_FORCE: state_nxt = vid_req_i ? VID : IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en_o    = vid_gnt_o | spi_gnt_o;
    mem_we_o    = spi_gnt_o & spi_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (vid_gnt_o) begin
      mem_addr_o = vid_addr_i;
    end else if (spi_gnt_o) begin
      mem_addr_o  = spi_addr_i;
      mem_wdata_o = spi_wdata_i;
    end
  end

  assign stall_inc = vid_req_i && !vid_gnt_o;
  assign stall_sum = (stall_inc && stall_cnt != 8'hff) ? stall_cnt + 8'd1 : stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      stall_cnt    <= 8'd0;
      stall_last_o <= 8'd0;
      vid_pend     <= 1'b0;
      spi_pend     <= 1'b0;
      vid_rdata_q  <= '0;
      spi_rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (spi_gnt_o || !spi_req_i) wait_cnt <= 4'd0;
      else if (wait_cnt != 4'hf)   wait_cnt <= wait_cnt + 4'd1;
      vid_pend <= vid_gnt_o;
      spi_pend <= spi_gnt_o & ~spi_we_i;
      if (vid_pend) vid_rdata_q <= mem_rdata_i;
      if (spi_pend) spi_rdata_q <= mem_rdata_i;
      if (next_frame_i) begin
        stall_last_o <= stall_sum;
        stall_cnt    <= 8'd0;
      end else begin
        stall_cnt <= stall_sum;
      end
    end
  end

  // rvalid is masked while reset is asserted so a read granted just before
  // reset never reports data.
  assign vid_rvalid_o = vid_pend & ~rst_i;
  assign spi_rvalid_o = spi_pend & ~rst_i;
  assign vid_rdata_o  = vid_pend ? mem_rdata_i : vid_rdata_q;
  assign spi_rdata_o  = spi_pend ? mem_rdata_i : spi_rdata_q;

  assign dbg_state_o = state;
  assign dbg_wait_o  = wait_cnt;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus randomized
// protocol-legal traffic compared every cycle against a behavioural model.
module tb_fb_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_req, spi_req, spi_we, next_frame;
  logic [AW-1:0] vid_addr, spi_addr;
  logic [DW-1:0] spi_wdata, mem_rdata;
  logic          vid_gnt, vid_rvalid, spi_gnt, spi_rvalid;
  logic [DW-1:0] vid_rdata, spi_rdata, mem_wdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    stall_last;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_wait;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_i(rst),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_gnt_o(vid_gnt),
    .vid_rvalid_o(vid_rvalid), .vid_rdata_o(vid_rdata),
    .spi_req_i(spi_req), .spi_we_i(spi_we), .spi_addr_i(spi_addr),
    .spi_wdata_i(spi_wdata), .spi_gnt_o(spi_gnt), .spi_rvalid_o(spi_rvalid),
    .spi_rdata_o(spi_rdata), .next_frame_i(next_frame),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_last_o(stall_last), .dbg_state_o(dbg_state), .dbg_wait_o(dbg_wait)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit         m_valid = 1'b0;
  int         m_wait, m_stall;
  bit         m_force, m_vpend, m_spend;
  logic [7:0] m_vhold, m_shold, m_last;
  bit         eg_vid, eg_spi;
  int         stall_seen;

  // Per-cycle snapshots of DUT outputs for directed literal checks
  logic          s_vid_gnt, s_spi_gnt, s_en, s_we, s_vrv, s_srv;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_vrd, s_srd;
  logic [7:0]    s_last;
  logic [1:0]    s_state;
  logic [3:0]    s_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already driven; compare, advance model, clock.
  task automatic tick();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int sum;
    bit inc;
    #2;
    eg_spi = m_force ? spi_req : (!vid_req && spi_req);
    eg_vid = !m_force && vid_req;
    s_vid_gnt = vid_gnt; s_spi_gnt = spi_gnt; s_en = mem_en; s_we = mem_we;
    s_addr = mem_addr; s_wdata = mem_wdata; s_vrv = vid_rvalid; s_srv = spi_rvalid;
    s_vrd = vid_rdata; s_srd = spi_rdata; s_last = stall_last;
    s_state = dbg_state; s_wait = dbg_wait;
    if (m_valid) begin
      e_addr  = eg_vid ? vid_addr : (eg_spi ? spi_addr : '0);
      e_wdata = (eg_spi && !eg_vid) ? spi_wdata : '0;
      chk("vid_gnt", vid_gnt, eg_vid);
      chk("spi_gnt", spi_gnt, eg_spi);
      chk("mem_en", mem_en, eg_vid || eg_spi);
      chk("mem_we", mem_we, eg_spi && spi_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("vid_rvalid", vid_rvalid, m_vpend && !rst);
      chk("spi_rvalid", spi_rvalid, m_spend && !rst);
      chk("vid_rdata", vid_rdata, m_vpend ? mem_rdata : m_vhold);
      chk("spi_rdata", spi_rdata, m_spend ? mem_rdata : m_shold);
      chk("stall_last", stall_last, m_last);
    end
    if (rst) begin
      m_valid = 1'b1; m_wait = 0; m_stall = 0; m_force = 1'b0;
      m_vpend = 1'b0; m_spend = 1'b0; m_vhold = '0; m_shold = '0; m_last = '0;
    end else begin
      inc = vid_req && !eg_vid;
      if (inc) stall_seen++;
      if (m_vpend) m_vhold = mem_rdata;
      if (m_spend) m_shold = mem_rdata;
      m_vpend = eg_vid;
      m_spend = eg_spi && !spi_we;
      sum = m_stall + (inc ? 1 : 0);
      if (sum > 255) sum = 255;
      if (next_frame) begin m_last = 8'(sum); m_stall = 0; end
      else m_stall = sum;
      m_force = (m_wait == LIM) && spi_req && !eg_spi;
      if (eg_spi || !spi_req) m_wait = 0;
      else if (m_wait < 15) m_wait = m_wait + 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int spi_gnt_at, vid_gnt_n, n;
    rst = 1'b1; vid_req = 1'b0; spi_req = 1'b0; spi_we = 1'b0; next_frame = 1'b0;
    vid_addr = '0; spi_addr = '0; spi_wdata = '0; mem_rdata = '0;
    stall_seen = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_vid_gnt", s_vid_gnt, 0);
    chk("rst_spi_gnt", s_spi_gnt, 0);
    chk("rst_mem_en", s_en, 0);
    chk("rst_mem_we", s_we, 0);
    chk("rst_mem_addr", s_addr, 0);
    chk("rst_mem_wdata", s_wdata, 0);
    chk("rst_vid_rvalid", s_vrv, 0);
    chk("rst_spi_rvalid", s_srv, 0);
    chk("rst_vid_rdata", s_vrd, 0);
    chk("rst_spi_rdata", s_srd, 0);
    chk("rst_stall_last", s_last, 0);
    chk("rst_state", s_state, 0);
    chk("rst_wait", s_wait, 0);

    // SPI write, no video
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h0123; spi_wdata = 8'hA5;
    tick();
    chk("wr_gnt", s_spi_gnt, 1);
    chk("wr_en", s_en, 1);
    chk("wr_we", s_we, 1);
    chk("wr_addr", s_addr, 14'h0123);
    chk("wr_wdata", s_wdata, 8'hA5);
    spi_req = 1'b0; spi_we = 1'b0;
    tick();
    chk("wr_no_spi_rvalid", s_srv, 0);
    chk("wr_no_vid_rvalid", s_vrv, 0);

    // SPI read returning 0x3C
    spi_req = 1'b1; spi_addr = 14'h0010;
    tick();
    chk("rd_gnt", s_spi_gnt, 1);
    chk("rd_we", s_we, 0);
    spi_req = 1'b0; mem_rdata = 8'h3C;
    tick();
    chk("rd_rvalid", s_srv, 1);
    chk("rd_rdata", s_srd, 8'h3C);
    mem_rdata = 8'h00;
    tick();
    chk("rd_rvalid_once", s_srv, 0);
    chk("rd_rdata_held", s_srd, 8'h3C);

    // Starvation: continuous video, SPI raised at cycle 2
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    spi_gnt_at = -1; vid_gnt_n = 0;
    for (int c = 0; c < 20; c++) begin
      vid_req = 1'b1; vid_addr = AW'(c);
      if (c == 2) begin spi_req = 1'b1; spi_we = 1'b0; spi_addr = 14'h0055; end
      tick();
      if (s_vid_gnt) vid_gnt_n++;
      if (s_spi_gnt) begin spi_gnt_at = c; spi_req = 1'b0; end
    end
    chk("starve_spi_cycle", spi_gnt_at, 7);
    chk("starve_vid_grants", vid_gnt_n, 19);
    vid_req = 1'b0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    tick();
    chk("starve_stall_last", s_last, 1);

    // Simultaneous requests from IDLE
    vid_req = 1'b1; spi_req = 1'b1; spi_we = 1'b0; spi_addr = 14'h0077;
    tick();
    chk("both_vid_first", s_vid_gnt, 1);
    chk("both_spi_wait", s_spi_gnt, 0);
    tick();
    tick();
    vid_req = 1'b0;
    tick();
    chk("both_spi_after", s_spi_gnt, 1);
    chk("both_vid_after", s_vid_gnt, 0);
    spi_req = 1'b0;
    tick();

    // Stall saturation over 300 stall cycles
    vid_req = 1'b1; spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h0100; spi_wdata = 8'h5A;
    stall_seen = 0; n = 0;
    while (stall_seen < 300 && n < 3000) begin
      tick();
      n++;
    end
    chk("sat_budget", (stall_seen >= 300) ? 1 : 0, 1);
    vid_req = 1'b0; spi_req = 1'b0; spi_we = 1'b0; next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    tick();
    chk("sat_last", s_last, 255);
    for (int i = 0; i < 5; i++) tick();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    tick();
    chk("sat_next_frame", s_last, 0);

    // Reset right after a video read grant
    vid_req = 1'b1; vid_addr = 14'h0200;
    tick();
    chk("rstrd_gnt", s_vid_gnt, 1);
    vid_req = 1'b0; rst = 1'b1;
    tick();
    chk("rstrd_rvalid_in_rst", s_vrv, 0);
    rst = 1'b0;
    tick();
    chk("rstrd_rvalid_after", s_vrv, 0);
    chk("rstrd_state", s_state, 0);
    chk("rstrd_wait", s_wait, 0);

    // Randomized protocol-legal traffic
    for (int i = 0; i < 3000; i++) begin
      if (!vid_req || eg_vid) begin
        vid_req  = ($urandom_range(0, 9) < 6);
        vid_addr = AW'($urandom);
      end
      if (!spi_req || eg_spi) begin
        spi_req   = ($urandom_range(0, 9) < 5);
        spi_we    = 1'($urandom_range(0, 1));
        spi_addr  = AW'($urandom);
        spi_wdata = DW'($urandom);
      end
      next_frame = ($urandom_range(0, 39) == 0);
      mem_rdata  = DW'($urandom);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
